// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame geometry,
// used by the receiver and intended for the matching transmitter.
package uart_pkg;

    localparam int DEFAULT_N_OVERSAMPLE = 16;
    localparam int DEFAULT_NB_DATA      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous pad inputs. RST_VAL sets the level
// the chain holds during reset (1 for an idle-high serial line).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta_reg;
    logic sync_reg;

    // Two-stage capture of the asynchronous input into the clock domain.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= i_async;
            sync_reg <= meta_reg;
        end
    end

    assign o_sync = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver. Finds the start edge, re-centres on the
// middle of the start bit, samples each data bit at its centre, then checks
// the stop bit and delivers the byte with a one-clock done strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA      = DEFAULT_NB_DATA,
    parameter int N_OVERSAMPLE = DEFAULT_N_OVERSAMPLE,
    parameter int N_SB_TICK    = 16,
    parameter int NB_TICK_CNT  = 5,
    parameter int NB_BIT_CNT   = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam logic [NB_TICK_CNT-1:0] START_LAST = NB_TICK_CNT'(N_OVERSAMPLE / 2 - 1);
    localparam logic [NB_TICK_CNT-1:0] BIT_LAST   = NB_TICK_CNT'(N_OVERSAMPLE - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP_LAST  = NB_TICK_CNT'(N_SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  DATA_LAST  = NB_BIT_CNT'(NB_DATA - 1);

    uart_state_t            state_reg, state_next;
    logic [NB_TICK_CNT-1:0] tick_cnt_reg, tick_cnt_next;
    logic [NB_BIT_CNT-1:0]  bit_idx_reg, bit_idx_next;
    logic [NB_DATA-1:0]     shift_reg, shift_next;
    logic [NB_DATA-1:0]     data_reg, data_next;
    logic                   done_reg, done_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   rx_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    // State, counters, shift register and output holding registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            done_reg      <= done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic; everything except IDLE start detection waits for a tick.
    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        frame_err_next = frame_err_reg;
        done_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next    = ST_START;
                    tick_cnt_next = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt_reg == START_LAST) begin
                        if (!rx_s) begin
                            state_next    = ST_DATA;
                            tick_cnt_next = '0;
                            bit_idx_next  = '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt_reg == BIT_LAST) begin
                        shift_next    = {rx_s, shift_reg[NB_DATA-1:1]};
                        tick_cnt_next = '0;
                        if (bit_idx_reg == DATA_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt_reg == STOP_LAST) begin
                        data_next      = shift_reg;
                        done_next      = 1'b1;
                        frame_err_next = ~rx_s;
                        tick_cnt_next  = '0;
                        // A low stop bit may be a break; park until the line recovers.
                        state_next     = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_data      = data_reg;
    assign o_rx_done   = done_reg;
    assign o_frame_err = frame_err_reg;
    assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a line driver builds 8N1 frames at a chosen
// bit time, a monitor records every done strobe, and each scenario compares
// the recorded strobes against the bytes/stop levels it sent.
module tb_uart_rx;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick  = 1'b0;
    logic       i_rx    = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int cycle        = 0;
    int tick_period  = 4;
    int tick_phase   = 0;
    int last_start   = 0;

    logic [7:0] obs_data_q[$];
    logic       obs_err_q[$];
    int         obs_cyc_q[$];

    uart_rx dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    initial forever #5 i_clock = ~i_clock;

    // Cycle counter and baud-tick generator: one-clock tick every tick_period clocks.
    initial begin
        forever begin
            @(posedge i_clock);
            cycle++;
            #1;
            tick_phase = (tick_phase + 1 >= tick_period) ? 0 : tick_phase + 1;
            i_tick = (tick_phase == 0);
        end
    end

    // Strobe monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge i_clock);
            if (o_rx_done === 1'b1) begin
                obs_data_q.push_back(o_data);
                obs_err_q.push_back(o_frame_err);
                obs_cyc_q.push_back(cycle);
            end
        end
    end

    // Global time limit.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_obs();
        obs_data_q.delete();
        obs_err_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic hold_line(input logic level, input int clocks);
        i_rx = level;
        repeat (clocks) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first; stop bit level and length chosen by the caller.
    task automatic send_frame(input logic [7:0] data, input logic stop_level,
                              input int bit_clks, input int stop_clks);
        last_start = cycle;
        hold_line(1'b0, bit_clks);
        for (int b = 0; b < 8; b++) hold_line(data[b], bit_clks);
        hold_line(stop_level, stop_clks);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (obs_data_q.size() < n && k < budget) begin
            @(posedge i_clock);
            #1;
            k++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) begin @(posedge i_clock); #1; end
        tests_run++;
        if (o_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", o_data); end
        tests_run++;
        if (o_rx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", o_rx_done); end
        tests_run++;
        if (o_frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        tests_run++;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_reset = 1'b0;
        hold_line(1'b1, 40);
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_single();
        int lat;
        tick_period = 4;
        hold_line(1'b1, 100);
        clear_obs();
        send_frame(8'h55, 1'b1, 64, 64);
        wait_strobes(1, 200);
        hold_line(1'b1, 32);
        tests_run++;
        if (obs_data_q.size() != 1) begin
            tests_failed++; $display("FAIL single_count: got %0d strobes want 1", obs_data_q.size());
        end else begin
            lat = obs_cyc_q[0] - last_start;
            tests_run++;
            if (obs_data_q[0] !== 8'h55) begin tests_failed++; $display("FAIL single_data: got %h want 55", obs_data_q[0]); end
            tests_run++;
            if (obs_err_q[0] !== 1'b0) begin tests_failed++; $display("FAIL single_ferr: got %b want 0", obs_err_q[0]); end
            tests_run++;
            if (lat < 604 || lat > 624) begin tests_failed++; $display("FAIL single_latency: got %0d clocks want 604..624", lat); end
            $display("[TB] single: data=%h ferr=%b latency=%0d", obs_data_q[0], obs_err_q[0], lat);
        end
        tests_run++;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        int gap;
        tick_period = 4;
        clear_obs();
        send_frame(8'hA3, 1'b1, 64, 64);
        send_frame(8'h0F, 1'b1, 64, 64);
        wait_strobes(2, 200);
        hold_line(1'b1, 32);
        tests_run++;
        if (obs_data_q.size() != 2) begin
            tests_failed++; $display("FAIL b2b_count: got %0d strobes want 2", obs_data_q.size());
        end else begin
            gap = obs_cyc_q[1] - obs_cyc_q[0];
            tests_run++;
            if (obs_data_q[0] !== 8'hA3) begin tests_failed++; $display("FAIL b2b_first: got %h want a3", obs_data_q[0]); end
            tests_run++;
            if (obs_data_q[1] !== 8'h0F) begin tests_failed++; $display("FAIL b2b_second: got %h want 0f", obs_data_q[1]); end
            tests_run++;
            if (gap < 636 || gap > 644) begin tests_failed++; $display("FAIL b2b_spacing: got %0d clocks want 636..644", gap); end
            $display("[TB] back_to_back: %h %h spacing=%0d", obs_data_q[0], obs_data_q[1], gap);
        end
    endtask

    task automatic test_glitch();
        tick_period = 4;
        clear_obs();
        hold_line(1'b0, 16);
        hold_line(1'b1, 400);
        tests_run++;
        if (obs_data_q.size() != 0) begin tests_failed++; $display("FAIL glitch_strobe: got %0d strobes want 0", obs_data_q.size()); end
        tests_run++;
        if (o_data !== 8'h0F) begin tests_failed++; $display("FAIL glitch_data: got %h want 0f", o_data); end
        tests_run++;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b want 0", o_busy); end
        $display("[TB] glitch: strobes=%0d data=%h", obs_data_q.size(), o_data);
    endtask

    task automatic test_break();
        tick_period = 4;
        clear_obs();
        send_frame(8'h00, 1'b0, 64, 64);
        hold_line(1'b0, 160);
        tests_run++;
        if (obs_data_q.size() != 1) begin
            tests_failed++; $display("FAIL break_count: got %0d strobes want 1", obs_data_q.size());
        end else begin
            tests_run++;
            if (obs_data_q[0] !== 8'h00) begin tests_failed++; $display("FAIL break_data: got %h want 00", obs_data_q[0]); end
            tests_run++;
            if (obs_err_q[0] !== 1'b1) begin tests_failed++; $display("FAIL break_ferr: got %b want 1", obs_err_q[0]); end
        end
        tests_run++;
        if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL break_busy: got %b want 1", o_busy); end
        hold_line(1'b1, 128);
        tests_run++;
        if (obs_data_q.size() != 1) begin tests_failed++; $display("FAIL break_extra: got %0d strobes want 1", obs_data_q.size()); end
        tests_run++;
        if (o_frame_err !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL break_recover: got ferr=%b busy=%b want ferr=1 busy=0", o_frame_err, o_busy);
        end
        clear_obs();
        send_frame(8'h81, 1'b1, 64, 64);
        wait_strobes(1, 200);
        tests_run++;
        if (obs_data_q.size() != 1) begin
            tests_failed++; $display("FAIL break_next_count: got %0d strobes want 1", obs_data_q.size());
        end else begin
            tests_run++;
            if (obs_data_q[0] !== 8'h81 || obs_err_q[0] !== 1'b0) begin
                tests_failed++; $display("FAIL break_next: got %h/%b want 81/0", obs_data_q[0], obs_err_q[0]);
            end
        end
        $display("[TB] break: frame 00 with low stop, then 81");
        hold_line(1'b1, 64);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        tick_period = 4;
        d = 8'hC3;
        clear_obs();
        hold_line(1'b0, 64);
        for (int b = 0; b < 4; b++) hold_line(d[b], 64);
        hold_line(d[4], 32);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(posedge i_clock);
        #1;
        tests_run++;
        if (o_data !== 8'h00 || o_rx_done !== 1'b0 || o_frame_err !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got data=%h done=%b ferr=%b busy=%b want all 0", o_data, o_rx_done, o_frame_err, o_busy);
        end
        i_reset = 1'b0;
        hold_line(1'b1, 400);
        tests_run++;
        if (obs_data_q.size() != 0) begin tests_failed++; $display("FAIL midreset_strobe: got %0d strobes want 0", obs_data_q.size()); end
        send_frame(8'h3C, 1'b1, 64, 64);
        wait_strobes(1, 200);
        tests_run++;
        if (obs_data_q.size() != 1) begin
            tests_failed++; $display("FAIL midreset_next_count: got %0d strobes want 1", obs_data_q.size());
        end else begin
            tests_run++;
            if (obs_data_q[0] !== 8'h3C || obs_err_q[0] !== 1'b0) begin
                tests_failed++; $display("FAIL midreset_next: got %h/%b want 3c/0", obs_data_q[0], obs_err_q[0]);
            end
        end
        $display("[TB] reset_midframe: aborted c3, then 3c");
        hold_line(1'b1, 64);
    endtask

    task automatic test_baud_tolerance();
        int bit_clks[2];
        bit_clks[0] = 2686;
        bit_clks[1] = 2530;
        tick_period = 163;
        hold_line(1'b1, 400);
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            send_frame(8'h5A, 1'b1, bit_clks[i], bit_clks[i]);
            wait_strobes(1, 3000);
            tests_run++;
            if (obs_data_q.size() != 1) begin
                tests_failed++; $display("FAIL baud_count[%0d]: got %0d strobes want 1", i, obs_data_q.size());
            end else begin
                tests_run++;
                if (obs_data_q[0] !== 8'h5A || obs_err_q[0] !== 1'b0) begin
                    tests_failed++; $display("FAIL baud_frame[%0d]: got %h/%b want 5a/0", i, obs_data_q[0], obs_err_q[0]);
                end
                $display("[TB] baud bit=%0d clocks: data=%h ferr=%b", bit_clks[i], obs_data_q[0], obs_err_q[0]);
            end
            hold_line(1'b1, 600);
        end
    endtask

    // Random bytes, tick spacings and stop-bit levels; expected = what was sent.
    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        int         bc;
        for (int i = 0; i < 10; i++) begin
            tick_period = $urandom_range(1, 5);
            bc   = 16 * tick_period;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            hold_line(1'b1, bc);
            clear_obs();
            send_frame(d, stop, bc, bc);
            if (!stop) begin
                hold_line(1'b0, 2 * bc);
                hold_line(1'b1, 2 * bc);
            end else begin
                hold_line(1'b1, $urandom_range(0, bc));
            end
            wait_strobes(1, 4 * bc);
            tests_run++;
            if (obs_data_q.size() != 1) begin
                tests_failed++; $display("FAIL random_count[%0d]: got %0d strobes want 1", i, obs_data_q.size());
            end else begin
                if (obs_data_q[0] !== d || obs_err_q[0] !== ~stop) begin
                    tests_failed++;
                    $display("FAIL random_frame[%0d]: got %h/%b want %h/%b", i, obs_data_q[0], obs_err_q[0], d, ~stop);
                end
                $display("[TB] random[%0d] period=%0d sent=%h stop=%b got=%h ferr=%b", i, tick_period, d, stop, obs_data_q[0], obs_err_q[0]);
            end
        end
        hold_line(1'b1, 100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_random();
        test_baud_tolerance();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
